// File: rtl/data_break_seq_if.sv
// Break-channel request bundle plus the memory port the sequencer drives.
// master = sequencer side, slave = devices/memory/CPU side.
interface data_break_seq_if #(
   parameter int NCHAN = 2
);
   logic                  cpu_slot;
   logic [NCHAN-1:0]      brk_req;
   logic [NCHAN-1:0]      brk_3cyc;
   logic [NCHAN-1:0]      brk_to_mem;
   logic [12*NCHAN-1:0]   brk_addr;
   logic [3*NCHAN-1:0]    brk_field;
   logic [12*NCHAN-1:0]   brk_wdata;
   logic [11:0]           mem_rdata;

   logic                  break_in_prog;
   logic [11:0]           mem_addr;
   logic [2:0]            mem_field;
   logic                  mem_rd;
   logic                  mem_we;
   logic [11:0]           mem_wdata;
   logic [11:0]           brk_rdata;
   logic [NCHAN-1:0]      brk_ack;
   logic [NCHAN-1:0]      brk_wc_ovf;
   logic [2:0]            brk_chan;

   modport master (
      input  cpu_slot, brk_req, brk_3cyc, brk_to_mem, brk_addr, brk_field,
             brk_wdata, mem_rdata,
      output break_in_prog, mem_addr, mem_field, mem_rd, mem_we, mem_wdata,
             brk_rdata, brk_ack, brk_wc_ovf, brk_chan
   );

   modport slave (
      output cpu_slot, brk_req, brk_3cyc, brk_to_mem, brk_addr, brk_field,
             brk_wdata, mem_rdata,
      input  break_in_prog, mem_addr, mem_field, mem_rd, mem_we, mem_wdata,
             brk_rdata, brk_ack, brk_wc_ovf, brk_chan
   );
endinterface

// File: rtl/data_break_seq.sv
// Data-break sequencer: steals memory cycles for NCHAN channels; ack at grant+3 (single) or grant+9 (three-cycle).
// No backpressure: memory completes every cycle in fixed X0/X1/X2 timing, the CPU simply holds while break_in_prog.
module data_break_seq #(
   parameter int          NCHAN   = 2,
   parameter int          RR      = 0,
   parameter logic [11:0] WC_BASE = 12'o7750
) (
   input  logic             clk,
   input  logic             reset,
   data_break_seq_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, WC0, WC1, WC2, CA0, CA1, CA2, DB0, DB1, DB2
   } state_t;

   state_t      r_state, w_next;
   logic [2:0]  r_chan, r_ptr, r_field;
   logic        r_to_mem, r_ovf, r_bip;
   logic [11:0] r_xaddr, r_wdata, r_inc, r_rdata;

   logic        w_gnt_vld, w_grant;
   logic [2:0]  w_gnt_ch;
   int          w_best, w_dist;
   logic        w_sel_3cyc, w_sel_to_mem;
   logic [2:0]  w_sel_field;
   logic [11:0] w_sel_addr, w_sel_wdata;
   logic [11:0] w_wc_addr, w_ca_addr;

   logic             w_mem_rd, w_mem_we;
   logic [11:0]      w_mem_addr, w_mem_wdata;
   logic [2:0]       w_mem_field;
   logic [NCHAN-1:0] w_chan_oh, w_ack, w_ovf;

   // Round-robin ranks channel i by its distance past the last grant; fixed priority ranks by index.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_ch  = 3'd0;
      w_best    = 0;
      w_dist    = 0;
      for (int i = 0; i < NCHAN; i++) begin
         if (RR != 0) w_dist = (i + 2*NCHAN - int'(r_ptr) - 1) % NCHAN;
         else         w_dist = i;
         if (bus.brk_req[i] && (!w_gnt_vld || w_dist < w_best)) begin
            w_gnt_vld = 1'b1;
            w_gnt_ch  = 3'(i);
            w_best    = w_dist;
         end
      end
   end

   always_comb begin
      w_sel_3cyc   = 1'b0;
      w_sel_to_mem = 1'b0;
      w_sel_field  = 3'd0;
      w_sel_addr   = 12'd0;
      w_sel_wdata  = 12'd0;
      for (int i = 0; i < NCHAN; i++) begin
         if (w_gnt_ch == 3'(i)) begin
            w_sel_3cyc   = bus.brk_3cyc[i];
            w_sel_to_mem = bus.brk_to_mem[i];
            w_sel_field  = bus.brk_field[3*i +: 3];
            w_sel_addr   = bus.brk_addr[12*i +: 12];
            w_sel_wdata  = bus.brk_wdata[12*i +: 12];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NCHAN; i++) w_chan_oh[i] = (r_chan == 3'(i));
   end

   assign w_grant   = (r_state == IDLE) && bus.cpu_slot && w_gnt_vld;
   assign w_wc_addr = WC_BASE + {8'd0, r_chan, 1'b0};
   assign w_ca_addr = w_wc_addr + 12'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_mem_rd    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = 12'd0;
      w_mem_field = 3'd0;
      w_mem_wdata = 12'd0;
      w_ack       = '0;
      w_ovf       = '0;
      case (r_state)
         IDLE: if (w_grant) w_next = w_sel_3cyc ? WC0 : DB0;
         WC0: begin
            w_next     = WC1;
            w_mem_rd   = 1'b1;
            w_mem_addr = w_wc_addr;
         end
         WC1: w_next = WC2;
         WC2: begin
            w_next      = CA0;
            w_mem_we    = 1'b1;
            w_mem_addr  = w_wc_addr;
            w_mem_wdata = r_inc;
         end
         CA0: begin
            w_next     = CA1;
            w_mem_rd   = 1'b1;
            w_mem_addr = w_ca_addr;
         end
         CA1: w_next = CA2;
         CA2: begin
            w_next      = DB0;
            w_mem_we    = 1'b1;
            w_mem_addr  = w_ca_addr;
            w_mem_wdata = r_inc;
         end
         DB0: begin
            w_next = DB1;
            if (!r_to_mem) begin
               w_mem_rd    = 1'b1;
               w_mem_addr  = r_xaddr;
               w_mem_field = r_field;
            end
         end
         DB1: w_next = DB2;
         DB2: begin
            w_next = IDLE;
            w_ack  = w_chan_oh;
            if (r_ovf) w_ovf = w_chan_oh;
            if (r_to_mem) begin
               w_mem_we    = 1'b1;
               w_mem_addr  = r_xaddr;
               w_mem_field = r_field;
               w_mem_wdata = r_wdata;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chan   <= 3'd0;
         r_ptr    <= 3'(NCHAN-1);
         r_field  <= 3'd0;
         r_to_mem <= 1'b0;
         r_ovf    <= 1'b0;
         r_bip    <= 1'b0;
         r_xaddr  <= 12'd0;
         r_wdata  <= 12'd0;
         r_inc    <= 12'd0;
         r_rdata  <= 12'd0;
      end else begin
         r_bip <= (w_next != IDLE);
         if (w_grant) begin
            r_chan   <= w_gnt_ch;
            r_field  <= w_sel_field;
            r_to_mem <= w_sel_to_mem;
            r_xaddr  <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_ovf    <= 1'b0;
            if (RR != 0) r_ptr <= w_gnt_ch;
         end
         case (r_state)
            WC1: begin
               r_inc <= bus.mem_rdata + 12'd1;
               r_ovf <= (bus.mem_rdata == 12'o7777);
            end
            // The incremented current address is also the transfer address.
            CA1: begin
               r_inc   <= bus.mem_rdata + 12'd1;
               r_xaddr <= bus.mem_rdata + 12'd1;
            end
            DB1: if (!r_to_mem) r_rdata <= bus.mem_rdata;
            default: ;
         endcase
      end
   end

   assign bus.break_in_prog = r_bip;
   assign bus.mem_rd        = w_mem_rd;
   assign bus.mem_we        = w_mem_we;
   assign bus.mem_addr      = w_mem_addr;
   assign bus.mem_field     = w_mem_field;
   assign bus.mem_wdata     = w_mem_wdata;
   assign bus.brk_rdata     = r_rdata;
   assign bus.brk_ack       = w_ack;
   assign bus.brk_wc_ovf    = w_ovf;
   assign bus.brk_chan      = r_chan;

endmodule

// File: doc/data_break_seq.md
Name: data_break_seq

Overview:
- Parametrised data-break (DMA) sequencer that steals memory cycles from the major-state machine for NCHAN peripheral channels.
- Supports single-cycle breaks, where the device supplies the address, and three-cycle breaks, which do a word-count increment, then a current-address increment, then the transfer.
- Arbitrates between channels and drives the memory port while break_in_prog is high.
- Sits beside the major-state machine; the CPU offers a break window through cpu_slot.

Parameters:
- NCHAN, 2: number of break channels (1..8).
- RR, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin, starting after the last granted channel.
- WC_BASE, 12'o7750: field-0 base address. Channel ch word count is at WC_BASE+2*ch; its current address is at WC_BASE+2*ch+1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_slot  in  1  CPU is at a major-state boundary (F0/D0/E0); a break may start
- brk_req  in  NCHAN  per-channel break request, level
- brk_3cyc  in  NCHAN  1 = three-cycle break, 0 = single-cycle break
- brk_to_mem  in  NCHAN  1 = device to memory (write), 0 = memory to device (read)
- brk_addr  in  12*NCHAN  single-cycle transfer address; channel ch occupies slice ch
- brk_field  in  3*NCHAN  memory field for the data transfer
- brk_wdata  in  12*NCHAN  device write data
- mem_rdata  in  12  memory read data, valid the cycle after mem_rd
- break_in_prog  out  1  break sequence active; CPU holds its state
- mem_addr  out  12  memory address
- mem_field  out  3  memory field
- mem_rd  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  12  write data
- brk_rdata  out  12  data read for the device
- brk_ack  out  NCHAN  one-cycle pulse when the channel's transfer completes
- brk_wc_ovf  out  NCHAN  one-cycle pulse when the word count wraps to 0
- brk_chan  out  3  index of the granted channel

Behaviour:
- States: IDLE, WC0, WC1, WC2, CA0, CA1, CA2, DB0, DB1, DB2.
- Reset (asynchronous, takes effect immediately, including mid-sequence): state goes to IDLE. All outputs are 0 and mem_we drops at once. The round-robin pointer is set to channel NCHAN-1, so channel 0 has first priority.
- Grant: in IDLE, when cpu_slot=1 and |brk_req, the sequencer latches the winning channel, its mode, direction, field and data.
  - It moves to WC0 if brk_3cyc is set, otherwise to DB0.
  - With cpu_slot=0 it stays in IDLE regardless of requests.
- break_in_prog is registered and is 1 in every state except IDLE. It rises the cycle after the grant.
- Each memory cycle takes three states:
  - X0: drive mem_addr and assert mem_rd.
  - X1: capture mem_rdata.
  - X2: assert mem_we and drive mem_wdata.
- WC cycle: field 0, address WC_BASE+2*ch. The word count is written back as rdata+1 modulo 4096. If the result is 0, an overflow flag is latched.
- CA cycle: field 0, address WC_BASE+2*ch+1. The current address is written back as rdata+1 modulo 4096; a 7777 to 0000 wrap raises no flag. The incremented value becomes the transfer address (pre-increment).
- DB cycle: address is brk_addr (single-cycle) or the incremented CA (three-cycle). Field is brk_field.
  - Read (brk_to_mem=0): mem_rd is high in DB0. brk_rdata is loaded in DB1 and held until the next read break. No write in DB2.
  - Write (brk_to_mem=1): mem_rd stays 0. mem_we is high in DB2 with the latched brk_wdata.
- DB2: brk_ack[ch] pulses. brk_wc_ovf[ch] pulses in the same cycle if the overflow flag is set. Next state is IDLE.
- Latency: a single-cycle break occupies 3 cycles and a three-cycle break 9 cycles. The ack appears at grant+3 or grant+9.
- Dropping brk_req, or changing brk_* inputs, after the grant does not affect the sequence in progress.
- Back-to-back breaks: a new grant needs IDLE with cpu_slot=1. The earliest is the cycle after DB2.
- Round-robin: the pointer updates on grant. Search order is pointer+1, wrapping through NCHAN-1 to 0.
- mem_addr, mem_field and mem_wdata are 0 when no strobe is active.

Test Plan:
- Single-cycle read: ch0, brk_addr=0100, memory[0100]=1234, cpu_slot pulse -> break_in_prog high for 3 cycles, mem_rd in DB0, brk_rdata=1234, brk_ack[0] at grant+3, no mem_we.
- Three-cycle write: ch1, WC=7776, CA=0377, brk_wdata=5252 -> memory WC_BASE+2=7777, WC_BASE+3=0400, memory[0400]=5252, ack at grant+9, brk_wc_ovf=0. Repeat the break -> WC=0000 and brk_wc_ovf[1] pulses with the ack.
- Arbitration: ch0 and ch1 both request, RR=0 -> ch0 granted twice in a row. RR=1 -> ch0 then ch1.
- Gating: requests held with cpu_slot=0 -> no grant, break_in_prog stays 0. Drop brk_req mid-sequence -> sequence still completes and ack pulses.
- Reset in WC2 with mem_we high -> mem_we and break_in_prog fall immediately, state is IDLE, no ack, memory WC not written on the following clock.
